boot_fetch_rd_master: RTL and testbench

AXI4 read initiator that pulls a contiguous block out of the memory-mapped SPI flash port and streams it to a local consumer. Typical consumers are the boot loader copy engine and the instruction prefetch buffer. A single command (base address, beat count) is split into INCR bursts that never cross a 4 KB boundary and never exceed MAX_BURST beats. R data is forwarded beat-for-beat to a valid/ready output stream.

---
 rtl/boot_fetch_rd_master.sv | 167 ++++++++++++++++
 tb/tb_boot_fetch_rd_master.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_fetch_rd_master.sv
// AXI4 read initiator: splits one (address, beats) command into 4 KB-safe INCR bursts
// and streams R data to a valid/ready consumer. Define RID_CHECK_EN to flag unexpected RID values.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a command, cmd_ready high
// AR     | presenting the next burst on the AR channel
// DATA   | passing R beats of the outstanding burst to the output stream
// DONE   | one-cycle completion pulse
module boot_fetch_rd_master #(
    parameter int DW        = 128,
    parameter int AW        = 32,
    parameter int IDW       = 8,
    parameter int MAX_BURST = 16,
    parameter int ARID_VAL  = 0
) (
    input  logic           boot_fetch_aclk,
    input  logic           boot_fetch_areset,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [AW-1:0]  cmd_addr,
    input  logic [15:0]    cmd_beats,
    output logic           done,
    output logic           err,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  out_data,
    output logic           out_last,
    output logic [IDW-1:0] boot_fetch_arid,
    output logic [AW-1:0]  boot_fetch_araddr,
    output logic [7:0]     boot_fetch_arlen,
    output logic [2:0]     boot_fetch_arsize,
    output logic [1:0]     boot_fetch_arburst,
    output logic           boot_fetch_arvalid,
    input  logic           boot_fetch_arready,
    input  logic [IDW-1:0] boot_fetch_rid,
    input  logic [DW-1:0]  boot_fetch_rdata,
    input  logic [1:0]     boot_fetch_rresp,
    input  logic           boot_fetch_rlast,
    input  logic           boot_fetch_rvalid,
    output logic           boot_fetch_rready
);

    localparam int SZ = $clog2(DW / 8);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_DATA,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   rem_q, rem_d;
    logic [15:0]   beat_cnt_q, beat_cnt_d;
    logic          err_q, err_d;

    logic [15:0]   page_beats_c;
    logic [15:0]   len_c;
    logic          r_hs_c;
    logic          rid_err_c;
    logic          beat_err_c;

`ifdef RID_CHECK_EN
    assign rid_err_c = (boot_fetch_rid != IDW'(ARID_VAL));
`else
    logic unused_rid;
    assign unused_rid = ^boot_fetch_rid;
    assign rid_err_c  = 1'b0;
`endif

    // Burst length: bounded by what is left, MAX_BURST, and the beats before the next 4 KB page.
    always_comb begin
        page_beats_c = 16'((17'd4096 - {5'd0, addr_q[11:0]}) >> SZ);
        len_c        = rem_q;
        if (len_c > 16'(MAX_BURST)) begin
            len_c = 16'(MAX_BURST);
        end
        if (len_c > page_beats_c) begin
            len_c = page_beats_c;
        end
    end

    assign r_hs_c     = (state_q == S_DATA) && boot_fetch_rvalid && out_ready;
    assign beat_err_c = (boot_fetch_rresp != 2'b00)
                      || (boot_fetch_rlast != (beat_cnt_q == 16'd1))
                      || rid_err_c;

    always_ff @(posedge boot_fetch_aclk) begin
        if (boot_fetch_areset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr & ~AW'(DW / 8 - 1);
                    rem_d   = cmd_beats;
                    err_d   = 1'b0;
                    state_d = (cmd_beats == 16'd0) ? S_DONE : S_AR;
                end
            end
            S_AR: begin
                if (boot_fetch_arready) begin
                    beat_cnt_d = len_c;
                    state_d    = S_DATA;
                end
            end
            S_DATA: begin
                if (r_hs_c) begin
                    if (beat_err_c) begin
                        err_d = 1'b1;
                    end
                    beat_cnt_d = beat_cnt_q - 16'd1;
                    // Completion follows the local beat count; rlast only feeds the error flag.
                    if (beat_cnt_q == 16'd1) begin
                        rem_d   = rem_q - len_c;
                        addr_d  = addr_q + (AW'(len_c) << SZ);
                        state_d = (rem_q == len_c) ? S_DONE : S_AR;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        cmd_ready          = (state_q == S_IDLE);
        done               = (state_q == S_DONE);
        err                = err_q;
        boot_fetch_arvalid = (state_q == S_AR);
        boot_fetch_araddr  = (state_q == S_AR) ? addr_q : '0;
        boot_fetch_arlen   = (state_q == S_AR) ? 8'(len_c - 16'd1) : 8'd0;
        boot_fetch_arsize  = 3'(SZ);
        boot_fetch_arburst = 2'b01;
        boot_fetch_arid    = IDW'(ARID_VAL);
        boot_fetch_rready  = (state_q == S_DATA) && out_ready;
        out_valid          = (state_q == S_DATA) && boot_fetch_rvalid;
        out_data           = boot_fetch_rdata;
        out_last           = (state_q == S_DATA) && boot_fetch_rvalid
                           && (beat_cnt_q == 16'd1) && (rem_q == len_c);
    end

endmodule

// File: tb/tb_boot_fetch_rd_master.sv
// Bench for boot_fetch_rd_master: AXI read slave with a computed memory image, plus a
// command-level model (burst list, expected data stream, completion timing, sticky error).
module tb_boot_fetch_rd_master;

    localparam int DW = 128;
    localparam int AW = 32;
    localparam int IDW = 8;
    localparam int MB = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [AW-1:0]  cmd_addr;
    logic [15:0]    cmd_beats;
    logic           done;
    logic           err;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_data;
    logic           out_last;
    logic [IDW-1:0] arid;
    logic [AW-1:0]  araddr;
    logic [7:0]     arlen;
    logic [2:0]     arsize;
    logic [1:0]     arburst;
    logic           arvalid;
    logic           arready;
    logic [IDW-1:0] rid;
    logic [DW-1:0]  rdata;
    logic [1:0]     rresp;
    logic           rlast;
    logic           rvalid;
    logic           rready;

    always #5 clk = ~clk;

    boot_fetch_rd_master #(
        .DW(DW), .AW(AW), .IDW(IDW), .MAX_BURST(MB), .ARID_VAL(0)
    ) dut (
        .boot_fetch_aclk    (clk),
        .boot_fetch_areset  (rst),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_addr           (cmd_addr),
        .cmd_beats          (cmd_beats),
        .done               (done),
        .err                (err),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_data           (out_data),
        .out_last           (out_last),
        .boot_fetch_arid    (arid),
        .boot_fetch_araddr  (araddr),
        .boot_fetch_arlen   (arlen),
        .boot_fetch_arsize  (arsize),
        .boot_fetch_arburst (arburst),
        .boot_fetch_arvalid (arvalid),
        .boot_fetch_arready (arready),
        .boot_fetch_rid     (rid),
        .boot_fetch_rdata   (rdata),
        .boot_fetch_rresp   (rresp),
        .boot_fetch_rlast   (rlast),
        .boot_fetch_rvalid  (rvalid),
        .boot_fetch_rready  (rready)
    );

    typedef struct {
        logic [31:0] a;
        int          len;
    } burst_t;

    int checks = 0;
    int failures = 0;

    // command-level model state
    burst_t        exp_bq[$];
    logic [127:0]  exp_dq[$];
    burst_t        ar_log[$];
    bit            busy = 0;
    bit            in_flight = 0;
    bit            exp_err = 0;
    bit            exp_arv;
    bit            accepted = 0;
    int            cyc = 0;
    int            done_due = -10;
    int            ar_due = -10;
    int            m_left = 0;
    int            n_done = 0;

    // slave state and knobs
    bit            s_act = 0;
    logic [31:0]   s_addr = '0;
    int            s_left = 0;
    int            s_beat = 0;
    bit            rv_hold = 0;
    int            rv_pct = 100;
    int            ar_pct = 100;
    int            or_pct = 100;
    int            bad_beat = -1;
    int            bad_kind = 0;
    int            rnd_err_pct = 0;
    int            stall_at = -1;
    int            stall_cnt = 0;

    function automatic logic [127:0] mem_word(input logic [31:0] a);
        return {a, a ^ 32'hA5A5_5A5A, ~a, a + 32'h1234_5678};
    endfunction

    task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_accept(input logic [31:0] addr, input logic [15:0] beats);
        logic [31:0] a;
        int rem, len, page;
        a = addr & 32'hFFFF_FFF0;
        for (int i = 0; i < int'(beats); i++) exp_dq.push_back(mem_word(a + 32'(i) * 32'd16));
        rem = int'(beats);
        while (rem > 0) begin
            page = (4096 - int'(a[11:0])) / 16;
            len = rem;
            if (len > MB) len = MB;
            if (len > page) len = page;
            exp_bq.push_back('{a, len});
            a = a + 32'(len * 16);
            rem = rem - len;
        end
        exp_err = 0;
        busy = 1;
        s_beat = 0;
        if (beats == 16'd0) done_due = cyc + 1;
        else ar_due = cyc + 1;
    endtask

    // slave driver + per-cycle compare against the model
    initial begin
        wait (rst == 1'b0);
        forever begin
            @(negedge clk);
            if (stall_cnt > 0) begin
                out_ready = 1'b0;
                stall_cnt--;
            end else begin
                out_ready = ($urandom_range(99) < or_pct);
            end
            arready = ($urandom_range(99) < ar_pct);
            if (!rv_hold) begin
                if (s_act) begin
                    rvalid = ($urandom_range(99) < rv_pct);
                    rdata = mem_word(s_addr);
                    rlast = (s_left == 1);
                    rresp = 2'b00;
                    if (s_beat == bad_beat && bad_kind == 1) rresp = 2'b10;
                    if (s_beat == bad_beat && bad_kind == 2) rlast = ~rlast;
                    if ($urandom_range(99) < rnd_err_pct) rresp = 2'b11;
                    if ($urandom_range(99) < rnd_err_pct) rlast = ~rlast;
                end else begin
                    rvalid = 1'b0;
                    rlast = 1'b0;
                    rresp = 2'b00;
                end
            end
            #1;
            chk(cmd_ready == !busy, "cmd_ready", cmd_ready, !busy);
            chk(done == (cyc == done_due), "done", done, cyc == done_due);
            chk(err == exp_err, "err", err, exp_err);
            exp_arv = busy && !in_flight && exp_bq.size() > 0 && cyc >= ar_due;
            chk(arvalid == exp_arv, "arvalid", arvalid, exp_arv);
            if (arvalid && exp_bq.size() > 0) begin
                chk(araddr == exp_bq[0].a, "araddr", araddr, exp_bq[0].a);
                chk(arlen == 8'(exp_bq[0].len - 1), "arlen", arlen, 8'(exp_bq[0].len - 1));
                chk(arsize == 3'd4, "arsize", arsize, 3'd4);
                chk(arburst == 2'b01, "arburst", arburst, 2'b01);
                chk(arid == 8'd0, "arid", arid, 8'd0);
            end
            chk(out_valid == (in_flight && rvalid), "out_valid", out_valid, in_flight && rvalid);
            chk(rready == (in_flight && out_ready), "rready", rready, in_flight && out_ready);
            chk(out_last == (in_flight && rvalid && exp_dq.size() == 1), "out_last", out_last,
                in_flight && rvalid && exp_dq.size() == 1);
            if (out_valid && out_ready) begin
                chk(exp_dq.size() > 0, "extra_beat", exp_dq.size(), 1);
                if (exp_dq.size() > 0) begin
                    chk(out_data == exp_dq[0], "out_data", out_data, exp_dq[0]);
                    void'(exp_dq.pop_front());
                end
            end
            // model/slave updates for the edge that follows
            if (cmd_valid && cmd_ready) begin
                model_accept(cmd_addr, cmd_beats);
                accepted = 1;
            end
            if (arvalid && arready) begin
                ar_log.push_back('{araddr, int'(arlen) + 1});
                if (exp_bq.size() > 0) begin
                    m_left = exp_bq[0].len;
                    void'(exp_bq.pop_front());
                end
                in_flight = 1;
                s_act = 1;
                s_addr = araddr;
                s_left = int'(arlen) + 1;
            end
            if (rvalid && rready) begin
                if (rresp != 2'b00 || rlast != (m_left == 1)) exp_err = 1;
                s_addr = s_addr + 32'd16;
                s_left--;
                s_beat++;
                if (s_left <= 0) s_act = 0;
                if (s_beat == stall_at) stall_cnt = 5;
                m_left--;
                if (m_left <= 0) begin
                    in_flight = 0;
                    if (exp_bq.size() > 0) ar_due = cyc + 1;
                    else done_due = cyc + 1;
                end
            end
            rv_hold = rvalid && !rready;
            if (done) n_done++;
            if (cyc == done_due) busy = 0;
            cyc++;
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic run_cmd(input logic [31:0] a, input logic [15:0] n);
        int k;
        cmd_valid = 1'b1;
        cmd_addr = a;
        cmd_beats = n;
        accepted = 0;
        k = 0;
        while (!accepted && k < 3000) begin
            @(posedge clk);
            k++;
        end
        chk(accepted, "cmd_accept_timeout", accepted, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy || exp_dq.size() > 0 || exp_bq.size() > 0) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk(!busy && exp_dq.size() == 0, "idle_timeout", busy, 0);
        @(negedge clk);
    endtask

    task automatic chk_ar(input int idx, input logic [31:0] a, input int len);
        chk(ar_log.size() > idx, "ar_count", ar_log.size(), idx + 1);
        if (ar_log.size() > idx) begin
            chk(ar_log[idx].a == a, "ar_log_addr", ar_log[idx].a, a);
            chk(ar_log[idx].len == len, "ar_log_len", ar_log[idx].len, len);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        logic [31:0] ra;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr = '0;
        cmd_beats = '0;
        out_ready = 1'b0;
        arready = 1'b0;
        rid = '0;
        rdata = '0;
        rresp = 2'b00;
        rlast = 1'b0;
        rvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(cmd_ready == 1'b1, "rst_cmd_ready", cmd_ready, 1);
        chk(done == 1'b0, "rst_done", done, 0);
        chk(err == 1'b0, "rst_err", err, 0);
        chk(arvalid == 1'b0, "rst_arvalid", arvalid, 0);
        chk(rready == 1'b0, "rst_rready", rready, 0);
        chk(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
        chk(out_last == 1'b0, "rst_out_last", out_last, 0);
        chk(araddr == 32'd0, "rst_araddr", araddr, 0);
        chk(arlen == 8'd0, "rst_arlen", arlen, 0);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // single burst
        ar_log.delete();
        nd = n_done;
        run_cmd(32'h1000, 16'd4);
        wait_idle();
        chk(ar_log.size() == 1, "t1_ar_count", ar_log.size(), 1);
        chk_ar(0, 32'h1000, 4);
        chk(n_done == nd + 1, "t1_done_count", n_done - nd, 1);
        chk(err == 1'b0, "t1_err", err, 0);

        // 4 KB split
        ar_log.delete();
        run_cmd(32'h0FC0, 16'd8);
        wait_idle();
        chk(ar_log.size() == 2, "t2_ar_count", ar_log.size(), 2);
        chk_ar(0, 32'h0FC0, 4);
        chk_ar(1, 32'h1000, 4);

        // MAX_BURST split
        ar_log.delete();
        run_cmd(32'h0, 16'd40);
        wait_idle();
        chk(ar_log.size() == 3, "t3_ar_count", ar_log.size(), 3);
        chk_ar(0, 32'h000, 16);
        chk_ar(1, 32'h100, 16);
        chk_ar(2, 32'h200, 8);

        // SLVERR on beat 2, sticky until next acceptance
        bad_beat = 1;
        bad_kind = 1;
        run_cmd(32'h3000, 16'd4);
        wait_idle();
        bad_beat = -1;
        #2;
        chk(err == 1'b1, "t4_err_sticky", err, 1);
        @(negedge clk);
        run_cmd(32'h3100, 16'd2);
        #2;
        chk(err == 1'b0, "t4_err_cleared", err, 0);
        @(negedge clk);
        wait_idle();

        // consumer stall mid-burst
        stall_at = 3;
        run_cmd(32'h2000, 16'd16);
        wait_idle();
        stall_at = -1;

        // early rlast
        bad_beat = 0;
        bad_kind = 2;
        run_cmd(32'h4000, 16'd4);
        wait_idle();
        bad_beat = -1;
        #2;
        chk(err == 1'b1, "t6_rlast_err", err, 1);
        @(negedge clk);

        // zero-beat command
        ar_log.delete();
        run_cmd(32'h500, 16'd0);
        #2;
        chk(done == 1'b1, "t7_done", done, 1);
        chk(arvalid == 1'b0, "t7_arvalid", arvalid, 0);
        @(negedge clk);
        #2;
        chk(done == 1'b0, "t7_done_pulse", done, 0);
        chk(cmd_ready == 1'b1, "t7_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        chk(ar_log.size() == 0, "t7_no_ar", ar_log.size(), 0);

        // randomized traffic, back-to-back commands with cmd_valid held while busy
        rv_pct = 70;
        ar_pct = 60;
        or_pct = 75;
        rnd_err_pct = 3;
        for (int i = 0; i < 40; i++) begin
            ra = {18'($urandom_range(0, 3)), 14'($urandom_range(0, 16383))};
            if ($urandom_range(7) == 0) ra = 32'hFFFF_F000 | 32'($urandom_range(0, 4095));
            run_cmd(ra, 16'($urandom_range(0, 60)));
            if ($urandom_range(3) == 0) wait_idle();
        end
        wait_idle();
        chk(exp_dq.size() == 0, "end_data_drained", exp_dq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
